// File: rtl/snn_router_pkg.sv
// Shared encodings for the spike fan-out router: FSM states, config select values
// and the bit positions of fields inside pointer and synapse config words.
package snn_router_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      FETCH  = 2'd2,
      EMIT   = 2'd3
   } router_state_t;

   localparam logic CONFIG_SEL_PTR = 1'b0;
   localparam logic CONFIG_SEL_SYN = 1'b1;

   localparam int PTR_COUNT_LSB = 16;
   localparam int SYN_DEST_LSB  = 8;
   localparam int SYN_EXC_BIT   = 31;

endpackage

// File: rtl/spike_router_in_fifo.sv
// Synchronous FIFO buffering source spike IDs ahead of the fan-out FSM.
// Latency: a pushed entry is visible on rd_dat the cycle after the push.
// Backpressure: full is raised at DEPTH entries; pushes while full are ignored.
module spike_router_in_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign full   = (count == (AW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign do_wr  = wr_vld && !full;
   assign do_rd  = rd_rdy && !empty;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spike_fanout_router.sv
// Expands each fired source neuron ID into its weighted synaptic events; SPIKE_FANOUT_WEIGHT_SCALE_EN adds a saturating weight shift.
// Latency: spike pushed at cycle N gives first event valid at N+3; one event per 2 cycles after that.
// Backpressure: events hold until m-side ready; s-side ready drops only when the input FIFO is full.
module spike_fanout_router
   import snn_router_pkg::*;
#(
   parameter int NUM_NEURONS     = 64,
   parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS),
   parameter int WEIGHT_WIDTH    = 8,
   parameter int MAX_SYNAPSES    = 1024,
   parameter int SYN_ADDR_WIDTH  = $clog2(MAX_SYNAPSES),
   parameter int FANOUT_WIDTH    = 8,
   parameter int IN_FIFO_DEPTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
`ifdef SPIKE_FANOUT_WEIGHT_SCALE_EN
   input  logic [2:0]                 global_weight_shift,
`endif
   input  logic                       s_axis_spike_valid,
   input  logic [NEURON_ID_WIDTH-1:0] s_axis_spike_neuron_id,
   output logic                       s_axis_spike_ready,
   output logic                       m_axis_spike_valid,
   output logic [NEURON_ID_WIDTH-1:0] m_axis_spike_dest_id,
   output logic [WEIGHT_WIDTH-1:0]    m_axis_spike_weight,
   output logic                       m_axis_spike_exc_inh,
   input  logic                       m_axis_spike_ready,
   input  logic                       config_we,
   input  logic                       config_sel,
   input  logic [SYN_ADDR_WIDTH-1:0]  config_addr,
   input  logic [31:0]                config_data,
   output logic                       config_rejected,
   output logic [31:0]                event_count,
   output logic                       router_busy
);

   typedef struct packed {
      logic [FANOUT_WIDTH-1:0]   count;
      logic [SYN_ADDR_WIDTH-1:0] base;
   } ptr_entry_t;

   typedef struct packed {
      logic                       exc_inh;
      logic [NEURON_ID_WIDTH-1:0] dest_id;
      logic [WEIGHT_WIDTH-1:0]    weight;
   } syn_entry_t;

   router_state_t state_q, state_d;

   logic [NEURON_ID_WIDTH-1:0] fifo_head;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       fifo_pop;

   ptr_entry_t ptr_mem [NUM_NEURONS];
   ptr_entry_t ptr_rdata;
   syn_entry_t syn_mem [MAX_SYNAPSES];
   syn_entry_t syn_rdata;

   logic                      syn_rd_en;
   logic [SYN_ADDR_WIDTH-1:0] syn_rd_addr;
   logic [SYN_ADDR_WIDTH-1:0] syn_addr_q;
   logic [SYN_ADDR_WIDTH-1:0] syn_addr_next;
   logic [FANOUT_WIDTH-1:0]   remaining_q;

   logic       m_hs;
   logic       emit_done;
   logic       load_out;
   syn_entry_t out_d;
   syn_entry_t out_q;

   logic       cfg_ptr_in_range;
   logic       ptr_we;
   logic       syn_we;
   logic       cfg_reject;
   logic       cfg_unused;
   ptr_entry_t ptr_wdat;
   syn_entry_t syn_wdat;

   spike_router_in_fifo #(
      .WIDTH (NEURON_ID_WIDTH),
      .DEPTH (IN_FIFO_DEPTH)
   ) u_in_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (s_axis_spike_valid),
      .wr_dat (s_axis_spike_neuron_id),
      .rd_rdy (fifo_pop),
      .rd_dat (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign s_axis_spike_ready = !fifo_full;
   assign router_busy        = (state_q != IDLE) || !fifo_empty;

   // Config writes only land while idle so a fan-out never sees a half-updated table.
   assign cfg_ptr_in_range = (32'(config_addr) < 32'(NUM_NEURONS));
   assign ptr_we     = config_we && !router_busy && (config_sel == CONFIG_SEL_PTR) && cfg_ptr_in_range;
   assign syn_we     = config_we && !router_busy && (config_sel == CONFIG_SEL_SYN);
   assign cfg_reject = config_we && router_busy &&
                       ((config_sel == CONFIG_SEL_SYN) || cfg_ptr_in_range);
   assign cfg_unused = ^config_data;

   assign ptr_wdat.base    = config_data[SYN_ADDR_WIDTH-1:0];
   assign ptr_wdat.count   = config_data[PTR_COUNT_LSB +: FANOUT_WIDTH];
   assign syn_wdat.weight  = config_data[WEIGHT_WIDTH-1:0];
   assign syn_wdat.dest_id = config_data[SYN_DEST_LSB +: NEURON_ID_WIDTH];
   assign syn_wdat.exc_inh = config_data[SYN_EXC_BIT];

   always_ff @(posedge clk) begin
      if (ptr_we) begin
         ptr_mem[config_addr[NEURON_ID_WIDTH-1:0]] <= ptr_wdat;
      end
      if (fifo_pop) begin
         ptr_rdata <= ptr_mem[fifo_head];
      end
   end

   always_ff @(posedge clk) begin
      if (syn_we) begin
         syn_mem[config_addr] <= syn_wdat;
      end
      if (syn_rd_en) begin
         syn_rdata <= syn_mem[syn_rd_addr];
      end
   end

   assign syn_addr_next = (syn_addr_q == SYN_ADDR_WIDTH'(MAX_SYNAPSES - 1)) ?
                          '0 : syn_addr_q + SYN_ADDR_WIDTH'(1);

   assign m_hs = m_axis_spike_valid && m_axis_spike_ready;
   // A handshake taken while disabled clears valid; the advance is then made once enable returns.
   assign emit_done = m_hs || !m_axis_spike_valid;

   always_comb begin
      state_d     = state_q;
      fifo_pop    = 1'b0;
      syn_rd_en   = 1'b0;
      syn_rd_addr = syn_addr_q;
      load_out    = 1'b0;
      if (enable) begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_d  = LOOKUP;
               end
            end
            LOOKUP: begin
               if (ptr_rdata.count == '0) begin
                  state_d = IDLE;
               end else begin
                  syn_rd_en   = 1'b1;
                  syn_rd_addr = ptr_rdata.base;
                  state_d     = FETCH;
               end
            end
            FETCH: begin
               load_out = 1'b1;
               state_d  = EMIT;
            end
            EMIT: begin
               if (emit_done) begin
                  if (remaining_q > FANOUT_WIDTH'(1)) begin
                     syn_rd_en   = 1'b1;
                     syn_rd_addr = syn_addr_next;
                     state_d     = FETCH;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef SPIKE_FANOUT_WEIGHT_SCALE_EN
   logic [WEIGHT_WIDTH+6:0] wide_weight;
   assign wide_weight = {7'b0, syn_rdata.weight} << global_weight_shift;
   assign out_d.weight = (wide_weight[WEIGHT_WIDTH+6:WEIGHT_WIDTH] != '0) ?
                         '1 : wide_weight[WEIGHT_WIDTH-1:0];
`else
   assign out_d.weight = syn_rdata.weight;
`endif
   assign out_d.dest_id = syn_rdata.dest_id;
   assign out_d.exc_inh = syn_rdata.exc_inh;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= IDLE;
         m_axis_spike_valid <= 1'b0;
         out_q              <= '0;
         event_count        <= '0;
         config_rejected    <= 1'b0;
      end else begin
         state_q         <= state_d;
         config_rejected <= cfg_reject;
         if (m_hs) begin
            m_axis_spike_valid <= 1'b0;
            event_count        <= event_count + 32'd1;
         end
         if (load_out) begin
            m_axis_spike_valid <= 1'b1;
            out_q              <= out_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enable && (state_q == LOOKUP)) begin
         syn_addr_q  <= ptr_rdata.base;
         remaining_q <= ptr_rdata.count;
      end else if (enable && (state_q == EMIT) && emit_done) begin
         syn_addr_q  <= syn_addr_next;
         remaining_q <= remaining_q - FANOUT_WIDTH'(1);
      end
   end

   assign m_axis_spike_dest_id = out_q.dest_id;
   assign m_axis_spike_weight  = out_q.weight;
   assign m_axis_spike_exc_inh = out_q.exc_inh;

endmodule

// File: tb/tb_spike_fanout_router.sv
// Directed bench for spike_fanout_router: latency, ordering, wrap, backpressure, config rejection, reset abort.
module tb_spike_fanout_router;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
`ifdef SPIKE_FANOUT_WEIGHT_SCALE_EN
   logic [2:0]  global_weight_shift;
`endif
   logic        s_valid;
   logic [5:0]  s_id;
   logic        s_ready;
   logic        m_valid;
   logic [5:0]  m_dest;
   logic [7:0]  m_weight;
   logic        m_exc;
   logic        m_ready;
   logic        config_we;
   logic        config_sel;
   logic [9:0]  config_addr;
   logic [31:0] config_data;
   logic        config_rejected;
   logic [31:0] event_count;
   logic        router_busy;

   int n_checks = 0;
   int n_errors = 0;
   int ev_rd = 0;
   int exp_events = 0;
   logic [14:0] ev_log [$];

   always #5 clk = ~clk;

   spike_fanout_router dut (
      .clk                    (clk),
      .rst                    (rst),
      .enable                 (enable),
`ifdef SPIKE_FANOUT_WEIGHT_SCALE_EN
      .global_weight_shift    (global_weight_shift),
`endif
      .s_axis_spike_valid     (s_valid),
      .s_axis_spike_neuron_id (s_id),
      .s_axis_spike_ready     (s_ready),
      .m_axis_spike_valid     (m_valid),
      .m_axis_spike_dest_id   (m_dest),
      .m_axis_spike_weight    (m_weight),
      .m_axis_spike_exc_inh   (m_exc),
      .m_axis_spike_ready     (m_ready),
      .config_we              (config_we),
      .config_sel             (config_sel),
      .config_addr            (config_addr),
      .config_data            (config_data),
      .config_rejected        (config_rejected),
      .event_count            (event_count),
      .router_busy            (router_busy)
   );

   // Inputs change 1 ns after posedge, so a negedge sample of valid&&ready is a handshake at the next edge.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) ev_log.push_back({m_exc, m_dest, m_weight});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ev(input logic e, input logic [5:0] d, input logic [7:0] w);
      return {17'b0, e, d, w};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic sel, input logic [9:0] addr, input logic [31:0] data);
      config_we = 1'b1; config_sel = sel; config_addr = addr; config_data = data;
      tick();
      config_we = 1'b0;
   endtask

   task automatic push(input logic [5:0] id);
      int n = 0;
      s_valid = 1'b1; s_id = id;
      while (!s_ready && n < 500) begin tick(); n++; end
      check("push_ready", {31'b0, s_ready}, 32'd1);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (router_busy && n < 500) begin tick(); n++; end
      check(tag, {31'b0, router_busy}, 32'd0);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!m_valid && n < 500) begin tick(); n++; end
      check(tag, {31'b0, m_valid}, 32'd1);
   endtask

   task automatic next_ev(input string tag, input logic [31:0] exp);
      int n = 0;
      while (ev_log.size() <= ev_rd && n < 500) begin @(negedge clk); n++; end
      if (ev_log.size() > ev_rd) begin
         check(tag, {17'b0, ev_log[ev_rd]}, exp);
         ev_rd++;
      end else begin
         check(tag, 32'hFFFF_FFFF, exp);
      end
   endtask

   initial begin
      int lat;
      int logged;
      rst = 1'b1; enable = 1'b1; s_valid = 1'b0; s_id = '0; m_ready = 1'b1;
      config_we = 1'b0; config_sel = 1'b0; config_addr = '0; config_data = '0;
`ifdef SPIKE_FANOUT_WEIGHT_SCALE_EN
      global_weight_shift = 3'd0;
`endif
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_m_valid", {31'b0, m_valid}, 32'd0);
      check("rst_m_data", {17'b0, m_exc, m_dest, m_weight}, 32'd0);
      check("rst_s_ready", {31'b0, s_ready}, 32'd1);
      check("rst_event_count", event_count, 32'd0);
      check("rst_busy", {31'b0, router_busy}, 32'd0);
      check("rst_cfg_rej", {31'b0, config_rejected}, 32'd0);
      tick();

      // Tables for all scenarios.
      cfg(1'b0, 10'd3, 32'h0003_000A);
      cfg(1'b1, 10'd10, 32'h8000_0514);
      cfg(1'b1, 10'd11, 32'h0000_0607);
      cfg(1'b1, 10'd12, 32'h8000_0701);
      cfg(1'b0, 10'd0, 32'h0000_0000);
      cfg(1'b0, 10'd1, 32'h0002_03FF);
      cfg(1'b1, 10'd1023, 32'h8000_0921);
      cfg(1'b1, 10'd0, 32'h0000_0A2C);
      cfg(1'b0, 10'd2, 32'h0001_0014);
      cfg(1'b1, 10'd20, 32'h8000_0C64);
      cfg(1'b0, 10'd4, 32'h0002_001E);
      cfg(1'b1, 10'd30, 32'h8000_0130);
      cfg(1'b1, 10'd31, 32'h8000_0250);
      cfg(1'b0, 10'd100, 32'h0005_0000);
      @(negedge clk);
      check("ptr_oob_no_pulse", {31'b0, config_rejected}, 32'd0);
      tick();

      // Basic fan-out: three events, first valid three cycles after the push edge.
      push(6'd3);
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_valid && lat < 0) lat = i;
      end
      check("first_latency", lat, 32'd3);
      next_ev("t1_ev0", ev(1'b1, 6'd5, 8'd20));
      next_ev("t1_ev1", ev(1'b0, 6'd6, 8'd7));
      next_ev("t1_ev2", ev(1'b1, 6'd7, 8'd1));
      exp_events += 3;
      wait_idle("t1_idle");
      check("t1_event_count", event_count, exp_events);

      // Zero fan-out neuron.
      logged = ev_log.size();
      push(6'd0);
      repeat (3) @(negedge clk);
      check("t2_busy_low", {31'b0, router_busy}, 32'd0);
      repeat (10) @(negedge clk);
      check("t2_no_events", ev_log.size(), logged);
      check("t2_event_count", event_count, exp_events);
      tick();

      // Synapse address wraps from the last entry to zero.
      push(6'd1);
      next_ev("t3_ev0", ev(1'b1, 6'd9, 8'h21));
      next_ev("t3_ev1", ev(1'b0, 6'd10, 8'h2C));
      exp_events += 2;
      wait_idle("t3_idle");
      check("t3_event_count", event_count, exp_events);

      // Downstream stall: data held stable, input FIFO fills to depth, nothing lost.
      m_ready = 1'b0;
      push(6'd2);
      wait_valid("t4_valid");
      for (int i = 0; i < 8; i++) push(6'd2);
      check("t4_fifo_full", {31'b0, s_ready}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t4_stall_valid", {31'b0, m_valid}, 32'd1);
         check("t4_stall_data", {17'b0, m_exc, m_dest, m_weight}, ev(1'b1, 6'd12, 8'd100));
      end
      tick();
      m_ready = 1'b1;
      push(6'd2);
      for (int i = 0; i < 10; i++) next_ev("t4_ev", ev(1'b1, 6'd12, 8'd100));
      exp_events += 10;
      wait_idle("t4_idle");
      check("t4_event_count", event_count, exp_events);

      // Config write while busy is dropped with a one-cycle pulse.
      m_ready = 1'b0;
      push(6'd2);
      wait_valid("t5_valid");
      cfg(1'b1, 10'd10, 32'h0000_3F3F);
      @(negedge clk);
      check("t5_rej_pulse", {31'b0, config_rejected}, 32'd1);
      @(negedge clk);
      check("t5_rej_clear", {31'b0, config_rejected}, 32'd0);
      tick();
      m_ready = 1'b1;
      next_ev("t5_ev", ev(1'b1, 6'd12, 8'd100));
      exp_events += 1;
      tick();
      wait_idle("t5_idle");
      push(6'd3);
      next_ev("t5_tbl_ev0", ev(1'b1, 6'd5, 8'd20));
      next_ev("t5_tbl_ev1", ev(1'b0, 6'd6, 8'd7));
      next_ev("t5_tbl_ev2", ev(1'b1, 6'd7, 8'd1));
      exp_events += 3;
      wait_idle("t5_idle2");
      check("t5_event_count", event_count, exp_events);

      // Enable low: spike buffered but FSM does not move.
      enable = 1'b0;
      push(6'd3);
      repeat (10) @(negedge clk);
      check("en_no_valid", {31'b0, m_valid}, 32'd0);
      check("en_busy", {31'b0, router_busy}, 32'd1);
      tick();
      enable = 1'b1;
      next_ev("en_ev0", ev(1'b1, 6'd5, 8'd20));
      next_ev("en_ev1", ev(1'b0, 6'd6, 8'd7));
      next_ev("en_ev2", ev(1'b1, 6'd7, 8'd1));
      exp_events += 3;
      tick();
      wait_idle("en_idle");
      check("en_event_count", event_count, exp_events);

      // Reset mid-burst aborts fan-out and drops queued spikes; tables survive.
      m_ready = 1'b0;
      push(6'd3);
      push(6'd3);
      push(6'd3);
      wait_valid("rb_valid");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rb_m_valid", {31'b0, m_valid}, 32'd0);
      check("rb_busy", {31'b0, router_busy}, 32'd0);
      check("rb_s_ready", {31'b0, s_ready}, 32'd1);
      check("rb_event_count", event_count, 32'd0);
      tick();
      m_ready = 1'b1;
      logged = ev_log.size();
      repeat (20) @(negedge clk);
      check("rb_no_events", ev_log.size(), logged);
      tick();
      push(6'd3);
      next_ev("rb_ev0", ev(1'b1, 6'd5, 8'd20));
      next_ev("rb_ev1", ev(1'b0, 6'd6, 8'd7));
      next_ev("rb_ev2", ev(1'b1, 6'd7, 8'd1));
      tick();
      wait_idle("rb_idle");
      check("rb_event_count2", event_count, 32'd3);

`ifdef SPIKE_FANOUT_WEIGHT_SCALE_EN
      global_weight_shift = 3'd2;
      push(6'd4);
      next_ev("ws_ev0", ev(1'b1, 6'd1, 8'hC0));
      next_ev("ws_ev1", ev(1'b1, 6'd2, 8'hFF));
      tick();
      wait_idle("ws_idle");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
